dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: the processor load/store port (CPU) and a program/data loader port (DMA).
- Grants at most one access per cycle, with CPU priority and a starvation guard for DMA.
- Supports DMA locked bursts, capped so the CPU always gets a slot.
- Returns read data to the requester that issued the read, and drives a stall to the CPU when it loses arbitration.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/rd_tag_pipe.sv | 42 ++++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and default widths for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int unsigned DEF_AW         = 32;
   localparam int unsigned DEF_DW         = 32;
   localparam int unsigned DEF_RD_LAT     = 1;
   localparam int unsigned DEF_STARVE_MAX = 4;
   localparam int unsigned DEF_LOCK_MAX   = 8;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   // Bits needed to hold a counter that saturates at max.
   function automatic int unsigned cnt_w(input int unsigned max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipeline: tracks which requester owns each read in flight.
module rd_tag_pipe
   import dmem_arb_pkg::*;
#(
   parameter int unsigned Depth = DEF_RD_LAT
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   valid_i,
   input  owner_e owner_i,
   output logic   valid_o,
   output owner_e owner_o
);

   logic [Depth-1:0] valid_q, valid_d;
   logic [Depth-1:0] owner_q, owner_d;

   always_comb begin
      valid_d    = valid_q;
      owner_d    = owner_q;
      valid_d[0] = valid_i;
      owner_d[0] = owner_i;
      for (int unsigned i = 1; i < Depth; i++) begin
         valid_d[i] = valid_q[i-1];
         owner_d[i] = owner_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         owner_q <= '0;
      end else begin
         valid_q <= valid_d;
         owner_q <= owner_d;
      end
   end

   assign valid_o = valid_q[Depth-1];
   assign owner_o = owner_e'(owner_q[Depth-1]);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store port and the DMA loader,
// with CPU priority, a DMA starvation guard and capped DMA locked bursts.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW         = DEF_AW,
   parameter int unsigned DW         = DEF_DW,
   parameter int unsigned RD_LAT     = DEF_RD_LAT,
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
   parameter int unsigned LOCK_MAX   = DEF_LOCK_MAX
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          cpu_gnt_o,
   output logic          cpu_stall_o,
   output logic          cpu_rvalid_o,
   output logic [DW-1:0] cpu_rdata_o,
   input  logic          dma_req_i,
   input  logic          dma_we_i,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [DW-1:0] dma_wdata_i,
   input  logic          dma_lock_i,
   output logic          dma_gnt_o,
   output logic          dma_rvalid_o,
   output logic [DW-1:0] dma_rdata_o,
   output logic          mem_read_o,
   output logic          mem_write_o,
   output logic [AW-1:0] mem_address_o,
   output logic [DW-1:0] mem_write_data_o,
   input  logic [DW-1:0] mem_read_data_i
);

   localparam int unsigned SW = cnt_w(STARVE_MAX);
   localparam int unsigned LW = cnt_w(LOCK_MAX);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
   localparam logic [LW-1:0] LockMax   = LW'(LOCK_MAX);

   state_e        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [LW-1:0] lock_q, lock_d;

   logic   arb_cpu, arb_dma;
   logic   cpu_gnt, dma_gnt;
   logic   tag_valid;
   owner_e tag_owner;

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;

      // Plain arbitration: CPU first unless DMA has waited out its guard.
      arb_dma = dma_req_i & (~cpu_req_i | (starve_q == StarveMax));
      arb_cpu = cpu_req_i & ~arb_dma;

      unique case (state_q)
         ST_ARB: begin
            cpu_gnt = arb_cpu;
            dma_gnt = arb_dma;
            if (arb_dma && dma_lock_i) begin
               state_d = ST_LOCK;
               lock_d  = LW'(1);
            end
         end
         ST_LOCK: begin
            if (dma_req_i && dma_lock_i) begin
               if ((lock_q == LockMax) && cpu_req_i) begin
                  cpu_gnt = 1'b1;
                  lock_d  = '0;
               end else begin
                  dma_gnt = 1'b1;
                  if (lock_q != LockMax) begin
                     lock_d = lock_q + 1'b1;
                  end
               end
            end else begin
               // Burst over: fall back to plain arbitration in this same cycle.
               state_d = ST_ARB;
               lock_d  = '0;
               cpu_gnt = arb_cpu;
               dma_gnt = arb_dma;
            end
         end
         default: begin
            state_d = ST_ARB;
            lock_d  = '0;
         end
      endcase

      if (dma_req_i && !dma_gnt) begin
         starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
      end else begin
         starve_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= ST_ARB;
         starve_q <= '0;
         lock_q   <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         lock_q   <= lock_d;
      end
   end

   always_comb begin
      mem_read_o       = 1'b0;
      mem_write_o      = 1'b0;
      mem_address_o    = '0;
      mem_write_data_o = '0;
      if (cpu_gnt) begin
         mem_read_o       = ~cpu_we_i;
         mem_write_o      = cpu_we_i;
         mem_address_o    = cpu_addr_i;
         mem_write_data_o = cpu_wdata_i;
      end else if (dma_gnt) begin
         mem_read_o       = ~dma_we_i;
         mem_write_o      = dma_we_i;
         mem_address_o    = dma_addr_i;
         mem_write_data_o = dma_wdata_i;
      end
   end

   rd_tag_pipe #(
      .Depth (RD_LAT)
   ) u_rd_tag_pipe (
      .clk_i   (clk_i),
      .rst_ni  (reset_ni),
      .valid_i (mem_read_o),
      .owner_i (dma_gnt ? OWN_DMA : OWN_CPU),
      .valid_o (tag_valid),
      .owner_o (tag_owner)
   );

   assign cpu_gnt_o    = cpu_gnt;
   assign dma_gnt_o    = dma_gnt;
   assign cpu_stall_o  = cpu_req_i & ~cpu_gnt;
   assign cpu_rvalid_o = tag_valid & (tag_owner == OWN_CPU);
   assign dma_rvalid_o = tag_valid & (tag_owner == OWN_DMA);
   assign cpu_rdata_o  = cpu_rvalid_o ? mem_read_data_i : '0;
   assign dma_rdata_o  = dma_rvalid_o ? mem_read_data_i : '0;

endmodule
